// File: rtl/colour_pkg.sv
// Shared colour types and hue constants for the rgb2hsl / hsl2rgb paths.
package colour_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef struct packed {
      logic [7:0] h;
      logic [7:0] s;
      logic [7:0] l;
   } hsl_t;

   // One 60-degree hue sector in 256-step hue units, and the sector
   // offsets where green and blue dominate.
   localparam logic [7:0] HUE_SECTOR = 8'd43;
   localparam logic [7:0] HUE_G      = 8'd85;
   localparam logic [7:0] HUE_B      = 8'd171;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_DIV_S,
      ST_DIV_H,
      ST_DONE
   } conv_state_e;

   function automatic logic [7:0] max3(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
      logic [7:0] m;
      m = (a >= b) ? a : b;
      return (m >= c) ? m : c;
   endfunction

   function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
      logic [7:0] m;
      m = (a <= b) ? a : b;
      return (m <= c) ? m : c;
   endfunction

   function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/div_serial.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The start cycle already performs the first iteration on the incoming
// operands, so a division occupies exactly DIV_BITS clock edges and
// done_o pulses in the cycle right after the last one.
module div_serial #(
   parameter int DIV_BITS = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [DIV_BITS-1:0] dividend_i,
   input  logic [7:0]          divisor_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [DIV_BITS-1:0] quotient_o,
   output logic [7:0]          remainder_o
);

   localparam int CW = $clog2(DIV_BITS + 1);

   logic [7:0]          rem_q, rem_d;
   logic [DIV_BITS-1:0] dq_q, dq_d;      // dividend bits shift out, quotient bits shift in
   logic [7:0]          dvs_q, dvs_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [7:0]          src_rem;
   logic [DIV_BITS-1:0] src_dq;
   logic [7:0]          src_dvs;
   logic [8:0]          trial;
   logic [8:0]          trial_sub;
   logic                take;
   logic [7:0]          rem_step;
   logic [DIV_BITS-1:0] dq_step;

   // One restoring step on either fresh operands (start) or the running state
   always_comb begin
      src_rem   = start_i ? 8'd0 : rem_q;
      src_dq    = start_i ? dividend_i : dq_q;
      src_dvs   = start_i ? divisor_i : dvs_q;
      trial     = {src_rem, src_dq[DIV_BITS-1]};
      trial_sub = trial - {1'b0, src_dvs};
      // trial[8] set implies trial > any 8-bit divisor, so the subtract
      // result always fits back into 8 bits when taken.
      take      = (trial >= {1'b0, src_dvs});
      rem_step  = take ? trial_sub[7:0] : trial[7:0];
      dq_step   = {src_dq[DIV_BITS-2:0], take};
   end

   // Next-state: load+first step on start, then count down the remaining steps
   always_comb begin
      rem_d  = rem_q;
      dq_d   = dq_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (start_i) begin
         rem_d  = rem_step;
         dq_d   = dq_step;
         dvs_d  = divisor_i;
         cnt_d  = CW'(DIV_BITS - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         rem_d = rem_step;
         dq_d  = dq_step;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // Divider state registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rem_q  <= '0;
         dq_q   <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         dq_q   <= dq_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign quotient_o  = dq_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/rgb2hsl.sv
// RGB888 -> HSL888 converter. One pixel in flight; a single serial divider
// is shared, first for saturation and then for the hue fraction.
module rgb2hsl
   import colour_pkg::*;
#(
   parameter int DIV_BITS = 16   // must be >= 16 so delta*255 fits
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] r,
   input  logic [7:0] g,
   input  logic [7:0] b,
   input  logic       ready_i,
   output logic [7:0] h,
   output logic [7:0] s,
   output logic [7:0] l,
   output logic       valid_o,
   output logic       busy_o
);

   conv_state_e state_q, state_d;

   rgb_t       pix_q, pix_d;
   logic [7:0] delta_q, delta_d;
   logic [7:0] lgt_q, lgt_d;
   logic [7:0] habs_q, habs_d;
   logic [7:0] hoff_q, hoff_d;
   logic       hneg_q, hneg_d;
   logic       zero_q, zero_d;
   logic [7:0] sres_q, sres_d;
   logic [7:0] h_q, h_d;
   logic [7:0] s_q, s_d;
   logic [7:0] l_q, l_d;

   // PREP-stage values derived from the captured pixel
   logic [7:0]  mx_c, mn_c, delta_c;
   logic [8:0]  sum_c;
   logic [8:0]  sum_inv_c;
   logic [7:0]  habs_c, hoff_c;
   logic        hneg_c;
   logic [15:0] s_dvd_c, h_dvd_c;
   logic [7:0]  s_dvs_c, h_dvs_c;

   logic                div_start;
   logic [DIV_BITS-1:0] div_dvd;
   logic [7:0]          div_dvs;
   logic                div_busy, div_done;
   logic [DIV_BITS-1:0] div_quo;
   logic [7:0]          div_rem;
   logic [7:0]          hq;
   logic [7:0]          h_calc;
   logic                unused_div;

   // Extremes, lightness sum and the signed hue numerator of the held pixel
   always_comb begin
      mx_c      = max3(pix_q.r, pix_q.g, pix_q.b);
      mn_c      = min3(pix_q.r, pix_q.g, pix_q.b);
      delta_c   = mx_c - mn_c;
      sum_c     = {1'b0, mx_c} + {1'b0, mn_c};
      sum_inv_c = 9'd510 - sum_c;
      // Ties resolve r, then g, then b.
      if (pix_q.r >= pix_q.g && pix_q.r >= pix_q.b) begin
         hneg_c = (pix_q.g < pix_q.b);
         habs_c = absdiff(pix_q.g, pix_q.b);
         hoff_c = 8'd0;
      end else if (pix_q.g >= pix_q.b) begin
         hneg_c = (pix_q.b < pix_q.r);
         habs_c = absdiff(pix_q.b, pix_q.r);
         hoff_c = HUE_G;
      end else begin
         hneg_c = (pix_q.r < pix_q.g);
         habs_c = absdiff(pix_q.r, pix_q.g);
         hoff_c = HUE_B;
      end
   end

   // Divider operands; a grey pixel divides by 1 and the result is dropped
   always_comb begin
      s_dvd_c = {8'd0, delta_c} * 16'd255;
      if (delta_c == 8'd0)
         s_dvs_c = 8'd1;
      else if (sum_c <= 9'd255)
         s_dvs_c = sum_c[7:0];
      else
         s_dvs_c = sum_inv_c[7:0];
      h_dvd_c = {8'd0, habs_q} * {8'd0, HUE_SECTOR};
      h_dvs_c = zero_q ? 8'd1 : delta_q;
   end

   // FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (ready_i)  state_d = ST_PREP;
         ST_PREP:                state_d = ST_DIV_S;
         ST_DIV_S: if (div_done) state_d = ST_DIV_H;
         ST_DIV_H: if (div_done) state_d = ST_DONE;
         ST_DONE:                state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: handshake flags and divider launch (S from PREP, H when S finishes)
   always_comb begin
      busy_o    = (state_q != ST_IDLE);
      valid_o   = (state_q == ST_DONE);
      div_start = 1'b0;
      div_dvd   = DIV_BITS'(s_dvd_c);
      div_dvs   = s_dvs_c;
      if (state_q == ST_PREP) begin
         div_start = 1'b1;
      end else if (state_q == ST_DIV_S && div_done) begin
         div_start = 1'b1;
         div_dvd   = DIV_BITS'(h_dvd_c);
         div_dvs   = h_dvs_c;
      end
   end

   div_serial #(
      .DIV_BITS (DIV_BITS)
   ) u_div (
      .clk_i       (clock),
      .rst_i       (reset),
      .start_i     (div_start),
      .dividend_i  (div_dvd),
      .divisor_i   (div_dvs),
      .busy_o      (div_busy),
      .done_o      (div_done),
      .quotient_o  (div_quo),
      .remainder_o (div_rem)
   );

   // Both quotients are bounded to 8 bits; remainder is not needed.
   assign unused_div = ^{div_quo[DIV_BITS-1:8], div_rem, div_busy};

   // Hue = sector offset +/- fraction, wrapping mod 256
   always_comb begin
      hq     = div_quo[7:0];
      h_calc = hneg_q ? (hoff_q - hq) : (hoff_q + hq);
   end

   // Datapath next-state: capture, PREP snapshot, S result, final outputs
   always_comb begin
      pix_d   = pix_q;
      delta_d = delta_q;
      lgt_d   = lgt_q;
      habs_d  = habs_q;
      hoff_d  = hoff_q;
      hneg_d  = hneg_q;
      zero_d  = zero_q;
      sres_d  = sres_q;
      h_d     = h_q;
      s_d     = s_q;
      l_d     = l_q;
      if (state_q == ST_IDLE && ready_i)
         pix_d = '{r: r, g: g, b: b};
      if (state_q == ST_PREP) begin
         delta_d = delta_c;
         lgt_d   = sum_c[8:1];
         habs_d  = habs_c;
         hoff_d  = hoff_c;
         hneg_d  = hneg_c;
         zero_d  = (delta_c == 8'd0);
      end
      if (state_q == ST_DIV_S && div_done)
         sres_d = div_quo[7:0];
      if (state_q == ST_DIV_H && div_done) begin
         h_d = zero_q ? 8'd0 : h_calc;
         s_d = zero_q ? 8'd0 : sres_q;
         l_d = lgt_q;
      end
   end

   // Datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pix_q   <= '0;
         delta_q <= '0;
         lgt_q   <= '0;
         habs_q  <= '0;
         hoff_q  <= '0;
         hneg_q  <= 1'b0;
         zero_q  <= 1'b0;
         sres_q  <= '0;
         h_q     <= '0;
         s_q     <= '0;
         l_q     <= '0;
      end else begin
         pix_q   <= pix_d;
         delta_q <= delta_d;
         lgt_q   <= lgt_d;
         habs_q  <= habs_d;
         hoff_q  <= hoff_d;
         hneg_q  <= hneg_d;
         zero_q  <= zero_d;
         sres_q  <= sres_d;
         h_q     <= h_d;
         s_q     <= s_d;
         l_q     <= l_d;
      end
   end

   assign h = h_q;
   assign s = s_q;
   assign l = l_q;

endmodule

// File: tb/tb_rgb2hsl.sv
// Directed + random bench for rgb2hsl with a latency-tagged scoreboard.
module tb_rgb2hsl;
   import colour_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] r, g, b;
   logic       ready_i;
   logic [7:0] h, s, l;
   logic       valid_o, busy_o;

   int n_assert = 0;
   int n_fail   = 0;
   int ncyc     = 0;   // negedge counter, used to time valid_o

   typedef struct {
      hsl_t exp;
      int   cyc;
   } sb_t;
   sb_t sb[$];

   // {rgb, expected hsl}
   localparam logic [47:0] DIR [8] = '{
      48'h00FF00_55FF7F,
      48'h0000FF_ABFF7F,
      48'hFF00FF_D5FF7F,
      48'h646464_000064,
      48'hFFFFFF_0000FF,
      48'h000000_000000,
      48'hC89664_157996,
      48'hFF8080_00FFBF
   };

   always #5 clock = ~clock;

   rgb2hsl #(.DIV_BITS(16)) dut (
      .clock   (clock),
      .reset   (reset),
      .r       (r),
      .g       (g),
      .b       (b),
      .ready_i (ready_i),
      .h       (h),
      .s       (s),
      .l       (l),
      .valid_o (valid_o),
      .busy_o  (busy_o)
   );

   function automatic hsl_t ref_hsl(input int rr, input int gg, input int bb);
      int mx, mn, d, sm, num, off, q;
      hsl_t o;
      mx = (rr > gg) ? rr : gg;  mx = (mx > bb) ? mx : bb;
      mn = (rr < gg) ? rr : gg;  mn = (mn < bb) ? mn : bb;
      d  = mx - mn;
      sm = mx + mn;
      o.l = 8'(sm / 2);
      if (d == 0) begin
         o.h = 8'd0;
         o.s = 8'd0;
      end else begin
         o.s = 8'((sm <= 255) ? (d * 255 / sm) : (d * 255 / (510 - sm)));
         if (rr >= gg && rr >= bb) begin num = gg - bb; off = 0;   end
         else if (gg >= bb)        begin num = bb - rr; off = 85;  end
         else                      begin num = rr - gg; off = 171; end
         q   = ((num < 0) ? -num : num) * 43 / d;
         o.h = 8'((off + ((num < 0) ? -q : q)) & 255);
      end
      return o;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Output monitor: every valid_o must match the oldest pending pixel, on time
   always @(negedge clock) begin
      sb_t e;
      ncyc++;
      if (reset === 1'b0 && valid_o === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious_valid", 32'(valid_o), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("h", 32'(h), 32'(e.exp.h));
            chk("s", 32'(s), 32'(e.exp.s));
            chk("l", 32'(l), 32'(e.exp.l));
            chk("latency", 32'(ncyc), 32'(e.cyc));
         end
      end
   end

   // Present a pixel with ready_i for one cycle; valid_o due 34 cycles later
   task automatic accept(input logic [23:0] px, input hsl_t ex);
      sb_t e;
      @(negedge clock); #1;
      r = px[23:16]; g = px[15:8]; b = px[7:0];
      ready_i = 1'b1;
      e.exp = ex;
      e.cyc = ncyc + 34;
      sb.push_back(e);
      @(negedge clock); #1;
      ready_i = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clock); #1;
         if (valid_o) seen = 1'b1;
      end
      if (!seen) chk({tag, "_timeout"}, 32'(seen), 32'd1);
   endtask

   initial begin
      logic [47:0] ent;
      logic [23:0] px;
      reset = 1'b1; ready_i = 1'b0; r = '0; g = '0; b = '0;
      repeat (3) @(negedge clock);
      #1;
      chk("rst_h", 32'(h), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_l", 32'(l), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      reset = 1'b0;

      // Pure red, plus busy and pulse-width checks
      accept(24'hFF0000, '{h: 8'd0, s: 8'd255, l: 8'd127});
      chk("busy_after_accept", 32'(busy_o), 32'd1);
      wait_valid("red");
      @(negedge clock); #1;
      chk("valid_width", 32'(valid_o), 32'd0);
      chk("busy_idle", 32'(busy_o), 32'd0);

      // Directed table
      for (int i = 0; i < 8; i++) begin
         ent = DIR[i];
         accept(ent[47:24], ent[23:0]);
         wait_valid("directed");
      end

      // Second strobe mid-conversion is ignored
      accept(24'h0AC81E, ref_hsl(10, 200, 30));
      repeat (8) @(negedge clock);
      #1; r = 8'd5; g = 8'd6; b = 8'd7; ready_i = 1'b1;
      @(negedge clock); #1; ready_i = 1'b0;
      wait_valid("busy_ignore");
      repeat (40) @(negedge clock);

      // Strobe during DONE is ignored; accept right after valid_o is taken
      accept(24'h323CC8, ref_hsl(50, 60, 200));
      wait_valid("pre_b2b");
      r = 8'd1; g = 8'd2; b = 8'd3; ready_i = 1'b1;
      accept(24'h5A1EA0, ref_hsl(90, 30, 160));
      wait_valid("b2b");

      // Async reset in the middle of the hue division
      accept(24'h14F078, ref_hsl(20, 240, 120));
      repeat (24) @(negedge clock);
      #3 reset = 1'b1;
      #1;
      chk("abort_h", 32'(h), 32'd0);
      chk("abort_s", 32'(s), 32'd0);
      chk("abort_l", 32'(l), 32'd0);
      chk("abort_valid", 32'(valid_o), 32'd0);
      chk("abort_busy", 32'(busy_o), 32'd0);
      sb.delete();
      @(negedge clock); #1 reset = 1'b0;
      repeat (45) @(negedge clock);
      #1;
      chk("abort_idle_busy", 32'(busy_o), 32'd0);

      accept(24'h1E5A3C, ref_hsl(30, 90, 60));
      wait_valid("after_reset");

      // Random sweep
      for (int i = 0; i < 24; i++) begin
         px = 24'($urandom());
         accept(px, ref_hsl(int'(px[23:16]), int'(px[15:8]), int'(px[7:0])));
         wait_valid("random");
      end

      repeat (5) @(negedge clock);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rgb2hsl.md
Name: rgb2hsl

Overview:
- Converts one 8-bit RGB pixel to 8-bit HSL. It is the inverse of the hsl2rgb colour path.
- Used to analyse or round-trip colours in the Lissajous colour pipeline.
- Architecture: a single start strobe captures the input, a shared serial divider computes S and then H, and a one-cycle valid pulse presents the result.
- Latency is fixed and the block is not pipelined: one conversion is in flight at a time.

Parameters:
- DIV_BITS, 16, dividend/quotient width of the serial divider. It is also the iteration count per division.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- r  input  8  red, sampled when the start strobe is accepted
- g  input  8  green, sampled when the start strobe is accepted
- b  input  8  blue, sampled when the start strobe is accepted
- ready_i  input  1  start strobe, single-cycle
- h  output  8  hue; 256 steps = 360 degrees
- s  output  8  saturation
- l  output  8  lightness
- valid_o  output  1  one-cycle pulse; h/s/l are valid in that cycle and held afterwards
- busy_o  output  1  high while a conversion is in progress

Behaviour:
- Reset (async, active-high):
  - h, s, l = 0; valid_o = 0; busy_o = 0; FSM = IDLE.
  - Reset asserted mid-conversion aborts it; no valid_o follows.
- Accept: ready_i high at a rising edge while in IDLE latches r, g, b and moves to PREP.
  - ready_i while busy_o = 1 is ignored, including in the cycle valid_o is high.
  - Back-to-back operation: a new accept is allowed in the cycle after valid_o.
- FSM: IDLE -> PREP (1 cycle) -> DIV_S (DIV_BITS cycles) -> DIV_H (DIV_BITS cycles) -> DONE (1 cycle, valid_o = 1) -> IDLE.
  - Latency: valid_o is high exactly 2*DIV_BITS+2 = 34 cycles after the accepting edge.
  - busy_o is high from the edge after accept through DONE inclusive.
- PREP computes:
  - max, min, delta = max - min
  - sum = max + min (9 bits)
  - L = sum >> 1 (truncate)
- S:
  - If delta == 0: S = 0.
  - Else if sum <= 255: S = floor(delta*255 / sum).
  - Else: S = floor(delta*255 / (510 - sum)).
  - The divisor always fits 8 bits and the quotient is always <= 255.
- H:
  - Dominant channel priority on ties: r, then g, then b.
  - max == r: num = g - b, offset = 0.
  - max == g: num = b - r, offset = 85.
  - max == b: num = r - g, offset = 171.
  - q = floor(|num|*43 / delta), so q <= 43.
  - H = (offset + sign(num)*q) mod 256, two's-complement wrap.
  - If delta == 0: H = 0.
- Divider behaviour:
  - When delta == 0 the divisions still run with divisor forced to 1; the results are discarded.
  - Latency stays fixed, with no shortcut path.
- Outputs: h/s/l registers update only on entry to DONE and hold until the next DONE or reset.

Decomposition:
- Shared package colour_pkg:
  - rgb_t and hsl_t structs (3 x 8-bit)
  - constants HUE_SECTOR = 43, HUE_G = 85, HUE_B = 171
  - hsl2rgb uses the same constants.
- Sub-module div_serial:
  - Restoring unsigned divider: DIV_BITS-bit dividend, 8-bit divisor, one quotient bit per cycle.
  - Ports: start, busy, done, quotient, remainder.
  - Reused sequentially for S and then H.

Test Plan:
- (255,0,0) -> h=0, s=255, l=127; valid_o exactly 34 cycles after the accept edge, one cycle wide.
- (0,255,0) -> 85,255,127; (0,0,255) -> 171,255,127; (255,0,255) (r wins tie, negative num wraps) -> 213,255,127.
- Greys: (100,100,100) -> 0,0,100; (255,255,255) -> 0,0,255; (0,0,0) -> 0,0,0.
- (200,150,100) (sum > 255 branch) -> h=21, s=121, l=150; (255,128,128) -> 0,255,191.
- Busy and reset handling:
  - ready_i pulsed again mid-conversion with different RGB -> ignored; exactly one valid_o with the first result.
  - Async reset asserted mid-DIV_H -> all outputs 0 immediately, no valid_o afterwards.
  - A new accept after reset completes normally.
- Back-to-back: accept in the cycle after valid_o -> second result 34 cycles later.
- Random sweep: compare h/s/l against a reference model implementing the formulas above; every accepted pixel yields exactly one valid_o.
